// File: rtl/ms_timer_multi.sv
// Millisecond-style tick generator with a free-running tick counter and NUM_CH independent
// countdown channels (one-shot or periodic) that expire on tick boundaries.
module ms_timer_multi #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned TICK_HZ     = 1000,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned NUM_CH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  output logic [CNT_W-1:0]        tick_count,
  output logic                    tick,
  output logic                    wrap,
  input  logic [NUM_CH-1:0]       ch_load,
  input  logic [NUM_CH*CNT_W-1:0] ch_period,
  input  logic [NUM_CH-1:0]       ch_periodic,
  input  logic [NUM_CH-1:0]       ch_stop,
  output logic [NUM_CH-1:0]       ch_active,
  output logic [NUM_CH-1:0]       ch_expire
);

  localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(DIV - 1);

  if ((CLK_FREQ_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_div_check
    $error("ms_timer_multi: CLK_FREQ_HZ/TICK_HZ must be an integer >= 2");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_ch_check
    $error("ms_timer_multi: NUM_CH must be in 1..16");
  end

  logic [PW-1:0]                  presc_q, presc_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           tick_q, tick_d;
  logic                           wrap_q, wrap_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   rem_q, rem_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   reload_q, reload_d;
  logic [NUM_CH-1:0]              mode_q, mode_d;
  logic [NUM_CH-1:0]              active_q, active_d;
  logic [NUM_CH-1:0]              expire_q, expire_d;
  logic                           ts;

  always_comb begin
    ts = en & (presc_q == PrescMax) & ~clr;

    presc_d = presc_q;
    cnt_d   = cnt_q;
    if (clr) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (ts) begin
      presc_d = '0;
      cnt_d   = cnt_q + CNT_W'(1);
    end else if (en) begin
      presc_d = presc_q + PW'(1);
    end
    tick_d = ts;
    wrap_d = ts & (cnt_q == '1);

    rem_d    = rem_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    active_d = active_q;
    expire_d = '0;
    // Priority per channel: stop, then load (which swallows a coincident tick), then countdown.
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_stop[i]) begin
        active_d[i] = 1'b0;
      end else if (ch_load[i]) begin
        if (ch_period[i*CNT_W +: CNT_W] != '0) begin
          rem_d[i]    = ch_period[i*CNT_W +: CNT_W];
          reload_d[i] = ch_period[i*CNT_W +: CNT_W];
          mode_d[i]   = ch_periodic[i];
          active_d[i] = 1'b1;
        end else begin
          active_d[i] = 1'b0;
        end
      end else if (ts && active_q[i]) begin
        if (rem_q[i] > CNT_W'(1)) begin
          rem_d[i] = rem_q[i] - CNT_W'(1);
        end else begin
          expire_d[i] = 1'b1;
          if (mode_q[i]) begin
            rem_d[i] = reload_q[i];
          end else begin
            rem_d[i]    = '0;
            active_d[i] = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= '0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
      rem_q    <= '0;
      reload_q <= '0;
      mode_q   <= '0;
      active_q <= '0;
      expire_q <= '0;
    end else begin
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      wrap_q   <= wrap_d;
      rem_q    <= rem_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      active_q <= active_d;
      expire_q <= expire_d;
    end
  end

  assign tick_count = cnt_q;
  assign tick       = tick_q;
  assign wrap       = wrap_q;
  assign ch_active  = active_q;
  assign ch_expire  = expire_q;

endmodule
